flit_packetizer: RTL and testbench



---
 rtl/flit_packetizer.sv | 203 ++++++++++++++++++++
 tb/tb_flit_packetizer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_packetizer.sv
// ----------------------------------------------------------------------------
// flit_packetizer
// Transmit-side packetizer between a CPU and a NoC router injection port.
// A request (destination, body length) produces a header flit, then one
// numbered body flit per payload word; the last one is typed TAIL (or the
// single header is typed SINGLE when the length is zero). One packet is in
// flight at a time and the flit output is fully registered.
//
// Optional feature (macro FLIT_PACKETIZER_CHECKSUM_EN): all data flits are
// typed BODY and an extra TAIL flit carrying the XOR of the payloads follows,
// with flit_num = len+1. Request lengths are clamped to 2**FLIT_NUM_W-2.
//
// Ports:
//   nocclk, rst          clock, asynchronous active-high reset
//   self_id              static source node id
//   req_valid/req_ready  packet request handshake (req_dst, req_len)
//   data_valid/data_ready payload word handshake (data)
//   flit_valid/flit_ready output flit handshake (flit)
//   flit                 {type[1:0], src, dst, flit_num, payload}
//   busy                 packet in progress or output flit pending
// ----------------------------------------------------------------------------
module flit_packetizer #(
   parameter int NODE_ID_W  = 8,
   parameter int FLIT_NUM_W = 4,
   parameter int PAYLOAD_W  = 32,
   localparam int FLIT_W    = 2 + 2*NODE_ID_W + FLIT_NUM_W + PAYLOAD_W
) (
   input  logic                  nocclk,
   input  logic                  rst,
   input  logic [NODE_ID_W-1:0]  self_id,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NODE_ID_W-1:0]  req_dst,
   input  logic [FLIT_NUM_W-1:0] req_len,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [PAYLOAD_W-1:0]  data,
   output logic                  flit_valid,
   input  logic                  flit_ready,
   output logic [FLIT_W-1:0]     flit,
   output logic                  busy
);

   localparam logic [1:0] T_HEAD   = 2'b00;
   localparam logic [1:0] T_BODY   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BODY = 2'b01,
      S_CSUM = 2'b10
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic [NODE_ID_W-1:0]    dst_r, dst_nxt_s;
   logic [FLIT_NUM_W-1:0]   len_r, len_nxt_s;
   logic [FLIT_NUM_W-1:0]   cnt_r, cnt_nxt_s;
   logic                    flit_valid_r, flit_valid_nxt_s;
   logic [FLIT_W-1:0]       flit_r, flit_nxt_s;
   logic                    load_s;
   logic                    req_ready_s, data_ready_s;
   logic [FLIT_NUM_W-1:0]   len_eff_s;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
   logic [PAYLOAD_W-1:0]    csum_r, csum_nxt_s;
   // Longest body that still leaves a flit number free for the checksum flit.
   localparam logic [FLIT_NUM_W-1:0] LEN_MAX = {{(FLIT_NUM_W-1){1'b1}}, 1'b0};
`endif

   function automatic logic [FLIT_W-1:0] make_flit(
      input logic [1:0]            ftype,
      input logic [NODE_ID_W-1:0]  src,
      input logic [NODE_ID_W-1:0]  dst,
      input logic [FLIT_NUM_W-1:0] num,
      input logic [PAYLOAD_W-1:0]  payload
   );
      return {ftype, src, dst, num, payload};
   endfunction

   function automatic logic [PAYLOAD_W-1:0] xor_acc(
      input logic [PAYLOAD_W-1:0] acc,
      input logic [PAYLOAD_W-1:0] word
   );
      return acc ^ word;
   endfunction

   // The output register may take a new flit when empty or being handed off.
   assign load_s = ~flit_valid_r | flit_ready;

   // Effective body length latched for the packet (clamped when a checksum flit is appended).
   always_comb begin
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      if (req_len > LEN_MAX) begin
         len_eff_s = LEN_MAX;
      end else begin
         len_eff_s = req_len;
      end
`else
      len_eff_s = req_len;
`endif
   end

   // Next-state, handshake and next-flit logic.
   always_comb begin
      state_nxt_s      = state_r;
      dst_nxt_s        = dst_r;
      len_nxt_s        = len_r;
      cnt_nxt_s        = cnt_r;
      flit_nxt_s       = flit_r;
      flit_valid_nxt_s = flit_valid_r & ~flit_ready;
      req_ready_s      = 1'b0;
      data_ready_s     = 1'b0;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      csum_nxt_s       = csum_r;
`endif
      case (state_r)
         S_IDLE: begin
            // Held low during reset so no request is seen as accepted.
            req_ready_s = load_s & ~rst;
            if (req_valid && req_ready_s) begin
               dst_nxt_s        = req_dst;
               len_nxt_s        = len_eff_s;
               cnt_nxt_s        = {{(FLIT_NUM_W-1){1'b0}}, 1'b1};
               flit_valid_nxt_s = 1'b1;
               flit_nxt_s       = make_flit((req_len == {FLIT_NUM_W{1'b0}}) ? T_SINGLE : T_HEAD,
                                            self_id, req_dst, {FLIT_NUM_W{1'b0}},
                                            {{(PAYLOAD_W-FLIT_NUM_W){1'b0}}, req_len});
               state_nxt_s      = (req_len == {FLIT_NUM_W{1'b0}}) ? S_IDLE : S_BODY;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
               csum_nxt_s       = {PAYLOAD_W{1'b0}};
`endif
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_BODY: begin
            data_ready_s = load_s;
            if (data_valid && data_ready_s) begin
               cnt_nxt_s        = cnt_r + {{(FLIT_NUM_W-1){1'b0}}, 1'b1};
               flit_valid_nxt_s = 1'b1;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
               csum_nxt_s       = xor_acc(csum_r, data);
               flit_nxt_s       = make_flit(T_BODY, self_id, dst_r, cnt_r, data);
               state_nxt_s      = (cnt_r == len_r) ? S_CSUM : S_BODY;
`else
               flit_nxt_s       = make_flit((cnt_r == len_r) ? T_TAIL : T_BODY,
                                            self_id, dst_r, cnt_r, data);
               state_nxt_s      = (cnt_r == len_r) ? S_IDLE : S_BODY;
`endif
            end else begin
               state_nxt_s = S_BODY;
            end
         end
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
         S_CSUM: begin
            // cnt_r already equals len+1 after the last body flit.
            if (load_s) begin
               flit_valid_nxt_s = 1'b1;
               flit_nxt_s       = make_flit(T_TAIL, self_id, dst_r, cnt_r, csum_r);
               state_nxt_s      = S_IDLE;
            end else begin
               state_nxt_s = S_CSUM;
            end
         end
`endif
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, packet context and output flit registers.
   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         dst_r        <= {NODE_ID_W{1'b0}};
         len_r        <= {FLIT_NUM_W{1'b0}};
         cnt_r        <= {FLIT_NUM_W{1'b0}};
         flit_valid_r <= 1'b0;
         flit_r       <= {FLIT_W{1'b0}};
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
         csum_r       <= {PAYLOAD_W{1'b0}};
`endif
      end else begin
         state_r      <= state_nxt_s;
         dst_r        <= dst_nxt_s;
         len_r        <= len_nxt_s;
         cnt_r        <= cnt_nxt_s;
         flit_valid_r <= flit_valid_nxt_s;
         flit_r       <= flit_nxt_s;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
         csum_r       <= csum_nxt_s;
`endif
      end
   end

   assign req_ready  = req_ready_s;
   assign data_ready = data_ready_s;
   assign flit_valid = flit_valid_r;
   assign flit       = flit_r;
   assign busy       = (state_r != S_IDLE) | flit_valid_r;

endmodule

// File: tb/tb_flit_packetizer.sv
// ----------------------------------------------------------------------------
// tb_flit_packetizer
// Self-checking bench for flit_packetizer. Each queued packet is expanded by a
// packet-level model into its expected flit list; a compare process checks
// every handed-off flit against that list, plus hold/handshake rules while
// stalled. A few literal flits pin the model for the single-packet,
// zero-length and checksum cases.
// ----------------------------------------------------------------------------
module tb_flit_packetizer;
   localparam int NW  = 8;
   localparam int FW  = 4;
   localparam int PW  = 32;
   localparam int FLW = 2 + 2*NW + FW + PW;

   logic           nocclk = 1'b0;
   logic           rst = 1'b0;
   logic [NW-1:0]  self_id = 8'h03;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [NW-1:0]  req_dst = 8'h00;
   logic [FW-1:0]  req_len = 4'h0;
   logic           data_valid = 1'b0;
   logic           data_ready;
   logic [PW-1:0]  data = 32'h0;
   logic           flit_valid;
   logic           flit_ready = 1'b1;
   logic [FLW-1:0] flit;
   logic           busy;

   flit_packetizer dut (
      .nocclk(nocclk), .rst(rst), .self_id(self_id),
      .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst), .req_len(req_len),
      .data_valid(data_valid), .data_ready(data_ready), .data(data),
      .flit_valid(flit_valid), .flit_ready(flit_ready), .flit(flit), .busy(busy)
   );

   always #5 nocclk = ~nocclk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [FLW-1:0] exp_q[$];
   logic [FLW-1:0] seen_q[$];
   int             seen_cyc[$];
   logic [NW-1:0]  rq_dst[$];
   logic [FW-1:0]  rq_len[$];
   logic [PW-1:0]  dq[$];
   logic [PW-1:0]  wsrc[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [FLW-1:0] mk(input logic [1:0] t, input logic [NW-1:0] s,
                                         input logic [NW-1:0] d, input logic [FW-1:0] n,
                                         input logic [PW-1:0] p);
      return {t, s, d, n, p};
   endfunction

   // Packet model: queue the request, its payload words and its expected flits.
   task automatic queue_pkt(input logic [NW-1:0] dst, input logic [FW-1:0] len);
      int le;
      logic [PW-1:0] w;
      logic [PW-1:0] x;
      le = int'(len);
      x = 32'h0;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      if (le > 14) le = 14;
`endif
      rq_dst.push_back(dst);
      rq_len.push_back(len);
      exp_q.push_back(mk((len == 4'h0) ? 2'b11 : 2'b00, self_id, dst, 4'h0, {28'h0, len}));
      for (int i = 1; i <= le; i++) begin
         if (wsrc.size() > 0) w = wsrc.pop_front();
         else w = $urandom();
         dq.push_back(w);
         x = x ^ w;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
         exp_q.push_back(mk(2'b01, self_id, dst, 4'(i), w));
`else
         exp_q.push_back(mk((i == le) ? 2'b10 : 2'b01, self_id, dst, 4'(i), w));
`endif
      end
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      if (le > 0) exp_q.push_back(mk(2'b10, self_id, dst, 4'(le + 1), x));
`endif
   endtask

   task automatic feed_req(input int budget);
      bit got;
      while (rq_dst.size() > 0) begin
         req_valid = 1'b1;
         req_dst = rq_dst[0];
         req_len = rq_len[0];
         got = 1'b0;
         for (int t = 0; t < budget; t++) begin
            @(negedge nocclk);
            if (req_ready) begin got = 1'b1; break; end
         end
         if (!got) begin
            fail_now("req_timeout");
            rq_dst.delete(); rq_len.delete();
            req_valid = 1'b0;
            return;
         end
         @(posedge nocclk); #1;
         void'(rq_dst.pop_front());
         void'(rq_len.pop_front());
      end
      req_valid = 1'b0;
   endtask

   task automatic feed_data(input int budget);
      bit got;
      while (dq.size() > 0) begin
         data_valid = 1'b1;
         data = dq[0];
         got = 1'b0;
         for (int t = 0; t < budget; t++) begin
            @(negedge nocclk);
            if (data_ready) begin got = 1'b1; break; end
         end
         if (!got) begin
            fail_now("data_timeout");
            dq.delete();
            data_valid = 1'b0;
            return;
         end
         @(posedge nocclk); #1;
         void'(dq.pop_front());
      end
      data_valid = 1'b0;
   endtask

   task automatic drain(input string nm, input int budget);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         @(negedge nocclk);
         t++;
      end
      if (exp_q.size() != 0) begin
         fail_now({nm, "_drain_timeout"});
         exp_q.delete();
      end
      @(posedge nocclk); #1;
      check({nm, "_busy_after"}, 64'(busy), 64'h0);
      check({nm, "_valid_after"}, 64'(flit_valid), 64'h0);
   endtask

   task automatic run(input string nm, input int budget);
      fork
         feed_req(budget);
         feed_data(budget);
      join
      drain(nm, budget);
   endtask

   task automatic stall_after(input int k, input int ncyc);
      int t;
      t = 0;
      while (seen_q.size() < k && t < 300) begin
         @(negedge nocclk);
         t++;
      end
      @(posedge nocclk); #1;
      flit_ready = 1'b0;
      repeat (ncyc) @(posedge nocclk);
      #1;
      flit_ready = 1'b1;
   endtask

   // Cycle counter used to verify flits arrive on consecutive cycles.
   initial forever begin
      @(posedge nocclk);
      cyc++;
   end

   // Compare process: checks every handed-off flit and the stall rules.
   initial begin
      logic hold_pend;
      logic [FLW-1:0] hold_flit;
      hold_pend = 1'b0;
      hold_flit = '0;
      forever begin
         @(negedge nocclk);
         if (rst) begin
            hold_pend = 1'b0;
         end else begin
            if (hold_pend) begin
               check("hold_valid", 64'(flit_valid), 64'h1);
               check("hold_flit", 64'(flit), 64'(hold_flit));
            end
            if (flit_valid && !flit_ready) begin
               check("stall_data_ready", 64'(data_ready), 64'h0);
               check("stall_req_ready", 64'(req_ready), 64'h0);
            end
            if (flit_valid) check("busy_with_valid", 64'(busy), 64'h1);
            if (flit_valid && flit_ready) begin
               seen_q.push_back(flit);
               seen_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_flit: got %h, expected none", flit);
               end else begin
                  check("flit", 64'(flit), 64'(exp_q.pop_front()));
               end
            end
            hold_pend = flit_valid && !flit_ready;
            hold_flit = flit;
         end
      end
   end

   initial begin
      logic [FLW-1:0] lit;
      int b;
      int n;
      bit got;

      // Reset state
      #1 rst = 1'b1;
      repeat (2) @(negedge nocclk);
      check("rst_flit_valid", 64'(flit_valid), 64'h0);
      check("rst_flit", 64'(flit), 64'h0);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_data_ready", 64'(data_ready), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      @(posedge nocclk); #1;
      rst = 1'b0;

      // Single packet
      b = seen_q.size();
      wsrc.push_back(32'h11111111);
      wsrc.push_back(32'h22222222);
      queue_pkt(8'h0A, 4'd2);
      run("single", 100);
      lit = {2'b00, 8'h03, 8'h0A, 4'h0, 32'h00000002};
      check("single_lit_head", 64'(seen_q[b]), 64'(lit));
      lit = {2'b01, 8'h03, 8'h0A, 4'h1, 32'h11111111};
      check("single_lit_body", 64'(seen_q[b+1]), 64'(lit));
`ifndef FLIT_PACKETIZER_CHECKSUM_EN
      lit = {2'b10, 8'h03, 8'h0A, 4'h2, 32'h22222222};
      check("single_lit_tail", 64'(seen_q[b+2]), 64'(lit));
`endif
      check("single_consecutive", 64'(seen_cyc[b+2] - seen_cyc[b]), 64'd2);

      // Data offered in IDLE is not consumed
      data_valid = 1'b1;
      data = 32'hCAFEF00D;
      repeat (3) begin
         @(negedge nocclk);
         check("idle_data_ready", 64'(data_ready), 64'h0);
      end
      @(posedge nocclk); #1;
      data_valid = 1'b0;

      // Zero-length packet: req_ready high again on the cycle after acceptance
      b = seen_q.size();
      queue_pkt(8'h55, 4'd0);
      void'(rq_dst.pop_front());
      void'(rq_len.pop_front());
      req_valid = 1'b1;
      req_dst = 8'h55;
      req_len = 4'd0;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge nocclk);
         if (req_ready) begin got = 1'b1; break; end
      end
      if (!got) fail_now("zero_req_timeout");
      @(posedge nocclk); #1;
      req_valid = 1'b0;
      @(negedge nocclk);
      check("zero_flit_valid", 64'(flit_valid), 64'h1);
      check("zero_req_ready_again", 64'(req_ready), 64'h1);
      drain("zero", 50);
      lit = {2'b11, 8'h03, 8'h55, 4'h0, 32'h00000000};
      if (seen_q.size() > b) check("zero_lit_single", 64'(seen_q[b]), 64'(lit));
      else fail_now("zero_no_flit");

      // Backpressure mid-body
      queue_pkt(8'h21, 4'd4);
      b = seen_q.size();
      fork
         run("stall", 200);
         stall_after(b + 2, 5);
      join
      n = seen_q.size() - b;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      check("stall_flit_count", 64'(n), 64'd6);
`else
      check("stall_flit_count", 64'(n), 64'd5);
`endif

      // Back-to-back packets
      b = seen_q.size();
      queue_pkt(8'h31, 4'd1);
      queue_pkt(8'h32, 4'd1);
      run("b2b", 100);
      n = seen_q.size() - b;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      check("b2b_count", 64'(n), 64'd6);
`else
      check("b2b_count", 64'(n), 64'd4);
`endif
      if (n > 1) check("b2b_consecutive", 64'(seen_cyc[b+n-1] - seen_cyc[b]), 64'(n - 1));

      // Maximum length (clamped when the checksum flit is appended)
      queue_pkt(8'h7F, 4'd15);
      run("maxlen", 200);

      // Reset in the middle of a packet
      flit_ready = 1'b0;
      req_valid = 1'b1;
      req_dst = 8'h66;
      req_len = 4'd4;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge nocclk);
         if (req_ready) begin got = 1'b1; break; end
      end
      if (!got) fail_now("rstmid_req_timeout");
      @(posedge nocclk); #1;
      req_valid = 1'b0;
      check("rstmid_head_pending", 64'(flit_valid), 64'h1);
      #3 rst = 1'b1;
      #1;
      check("rstmid_valid", 64'(flit_valid), 64'h0);
      check("rstmid_flit", 64'(flit), 64'h0);
      check("rstmid_busy", 64'(busy), 64'h0);
      exp_q.delete();
      repeat (2) @(posedge nocclk);
      #1;
      rst = 1'b0;
      flit_ready = 1'b1;
      @(negedge nocclk);
      check("rstmid_after_valid", 64'(flit_valid), 64'h0);
      check("rstmid_after_req_ready", 64'(req_ready), 64'h1);
      @(posedge nocclk); #1;
      b = seen_q.size();
      queue_pkt(8'h44, 4'd1);
      run("after_rst", 100);
      if (seen_q.size() > b) begin
         lit = seen_q[b];
         check("after_rst_type", 64'(lit[53:52]), 64'h0);
         check("after_rst_num", 64'(lit[35:32]), 64'h0);
      end else begin
         fail_now("after_rst_no_flit");
      end

`ifdef FLIT_PACKETIZER_CHECKSUM_EN
      // Checksum flit
      b = seen_q.size();
      wsrc.push_back(32'h0F0F0000);
      wsrc.push_back(32'h00F0F0F0);
      queue_pkt(8'h0A, 4'd2);
      run("csum", 100);
      lit = {2'b01, 8'h03, 8'h0A, 4'h2, 32'h00F0F0F0};
      check("csum_lit_body2", 64'(seen_q[b+2]), 64'(lit));
      lit = {2'b10, 8'h03, 8'h0A, 4'h3, 32'h0FFFF0F0};
      check("csum_lit_tail", 64'(seen_q[b+3]), 64'(lit));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
